// File: rtl/ef_tcc32_pkg.sv
// Shared TCC32 definitions: edge-select encodings and default field widths
// reused by the event conditioner and the TCC32 register file.
package ef_tcc32_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_sel_e;

    localparam int TCC_SYNC_STAGES = 2;
    localparam int TCC_FLT_W       = 4;
    localparam int TCC_PRE_W       = 8;

endpackage

// File: rtl/ef_sync.sv
// N-stage synchroniser for a single asynchronous bit; resets to 0.
module ef_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ef_tcc32_evt_cond.sv
// External-event conditioner for the TCC32 ext_clk path: synchronise, glitch
// filter, edge select and prescale an asynchronous pin into single-cycle strobes.
module ef_tcc32_evt_cond
    import ef_tcc32_pkg::*;
#(
    parameter int SYNC_STAGES = TCC_SYNC_STAGES,
    parameter int FLT_W       = TCC_FLT_W,
    parameter int PRE_W       = TCC_PRE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ev_in,
    input  logic             pol,
    input  logic [FLT_W-1:0] flt_len,
    input  logic [1:0]       edge_sel,
    input  logic [PRE_W-1:0] pre,
    output logic             ev_level,
    output logic             ev_edge,
    output logic             ev_pulse
);

    logic             x;
    logic             s;
    logic             qual;
    logic             lvl_q,   lvl_d;
    logic [FLT_W-1:0] fcnt_q,  fcnt_d;
    logic [PRE_W-1:0] pcnt_q,  pcnt_d;
    logic             edge_q,  edge_d;
    logic             pulse_q, pulse_d;

    assign x = ev_in ^ pol;

    ef_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (x),
        .q     (s)
    );

    // Direction of a pending change is the value s is about to be adopted as.
    assign qual = (edge_sel == EDGE_BOTH)
               || ( s && (edge_sel == EDGE_RISE))
               || (!s && (edge_sel == EDGE_FALL));

    always_comb begin
        lvl_d   = lvl_q;
        fcnt_d  = fcnt_q;
        pcnt_d  = pcnt_q;
        edge_d  = 1'b0;
        pulse_d = 1'b0;
        if (!en) begin
            // Tracking while disabled means enabling never sees a stale level as an edge.
            lvl_d  = s;
            fcnt_d = '0;
            pcnt_d = '0;
        end else if (s == lvl_q) begin
            fcnt_d = '0;
        end else if (fcnt_q >= flt_len) begin
            lvl_d  = s;
            fcnt_d = '0;
            if (qual) begin
                edge_d = 1'b1;
                if (pcnt_q >= pre) begin
                    pcnt_d  = '0;
                    pulse_d = 1'b1;
                end else begin
                    pcnt_d = pcnt_q + PRE_W'(1);
                end
            end
        end else begin
            fcnt_d = fcnt_q + FLT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q   <= 1'b0;
            fcnt_q  <= '0;
            pcnt_q  <= '0;
            edge_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            lvl_q   <= lvl_d;
            fcnt_q  <= fcnt_d;
            pcnt_q  <= pcnt_d;
            edge_q  <= edge_d;
            pulse_q <= pulse_d;
        end
    end

    assign ev_level = lvl_q;
    assign ev_edge  = edge_q;
    assign ev_pulse = pulse_q;

endmodule

// File: tb/tb_ef_tcc32_evt_cond.sv
// Self-checking bench for ef_tcc32_evt_cond: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_ef_tcc32_evt_cond;

    localparam int SS = 2;
    localparam int FW = 4;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          ev_in = 1'b0;
    logic          pol = 1'b0;
    logic [FW-1:0] flt_len = '0;
    logic [1:0]    edge_sel = 2'b00;
    logic [PW-1:0] pre = '0;
    logic          ev_level;
    logic          ev_edge;
    logic          ev_pulse;

    ef_tcc32_evt_cond #(.SYNC_STAGES(SS), .FLT_W(FW), .PRE_W(PW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .ev_in    (ev_in),
        .pol      (pol),
        .flt_len  (flt_len),
        .edge_sel (edge_sel),
        .pre      (pre),
        .ev_level (ev_level),
        .ev_edge  (ev_edge),
        .ev_pulse (ev_pulse)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: pin history, consecutive-mismatch run and edges since last pulse.
    bit m_hist[SS];
    bit m_lvl, m_edge, m_pulse;
    int m_run, m_since;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < SS; i++) m_hist[i] = 1'b0;
        m_lvl = 0; m_edge = 0; m_pulse = 0; m_run = 0; m_since = 0;
    endtask

    task automatic model_step();
        bit s;
        bit want;
        s = m_hist[SS-1];
        for (int i = SS-1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = ev_in ^ pol;
        m_edge = 0;
        m_pulse = 0;
        if (!en) begin
            m_lvl = s; m_run = 0; m_since = 0;
        end else if (s == m_lvl) begin
            m_run = 0;
        end else if (m_run + 1 >= int'(flt_len) + 1) begin
            m_lvl = s;
            m_run = 0;
            want = (edge_sel == 2'b11) || (s && edge_sel == 2'b01) || (!s && edge_sel == 2'b10);
            if (want) begin
                m_edge = 1;
                if (m_since >= int'(pre)) begin
                    m_pulse = 1; m_since = 0;
                end else begin
                    m_since++;
                end
            end
        end else begin
            m_run++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("ev_level", ev_level, m_lvl);
        chk("ev_edge",  ev_edge,  m_edge);
        chk("ev_pulse", ev_pulse, m_pulse);
    endtask

    task automatic run_rec(input int n, output int pulses, output int edges, output int first_p);
        pulses = 0; edges = 0; first_p = 0;
        for (int k = 1; k <= n; k++) begin
            step();
            if (ev_edge) edges++;
            if (ev_pulse) begin
                pulses++;
                if (first_p == 0) first_p = k;
            end
        end
    endtask

    task automatic async_reset_check(input string tag);
        rst_n = 1'b0;
        #2;
        chk({tag, "_lvl"},   ev_level, 0);
        chk({tag, "_edge"},  ev_edge,  0);
        chk({tag, "_pulse"}, ev_pulse, 0);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int p, e, f, p2, e2, f2, hold, acc_p;
        model_reset();
        #12;
        chk("rst_lvl",   ev_level, 0);
        chk("rst_edge",  ev_edge,  0);
        chk("rst_pulse", ev_pulse, 0);
        rst_n = 1'b1;

        // Rising edge at defaults appears at edge 3; falling edge is not selected.
        en = 1; pol = 0; flt_len = 0; edge_sel = 2'b01; pre = 0; ev_in = 0;
        repeat (4) step();
        ev_in = 1;
        run_rec(10, p, e, f);
        chk("t1_first_pulse", f, 3);
        chk("t1_pulses", p, 1);
        chk("t1_edges", e, 1);
        ev_in = 0;
        run_rec(10, p, e, f);
        chk("t1_fall_pulses", p, 0);
        chk("t1_fall_lvl", ev_level, 0);

        // Glitch rejection with a four-cycle filter.
        flt_len = 3;
        step();
        ev_in = 1; run_rec(3, p, e, f);
        ev_in = 0; run_rec(10, p2, e2, f2);
        chk("t2_glitch_pulses", p + p2, 0);
        chk("t2_glitch_edges", e + e2, 0);
        ev_in = 1; run_rec(4, p, e, f);
        ev_in = 0; run_rec(10, p2, e2, f2);
        chk("t2_pulses", p + p2, 1);
        chk("t2_first_pulse", (f != 0) ? f : 4 + f2, 6);

        // Both edges, divide by three.
        flt_len = 0; edge_sel = 2'b11; pre = 2;
        en = 0; step(); en = 1;
        acc_p = 0;
        for (int i = 1; i <= 9; i++) begin
            ev_in = ~ev_in;
            run_rec(4, p, e, f);
            chk("t3_edge", e, 1);
            chk("t3_pulse", p, (i % 3 == 0) ? 1 : 0);
            acc_p += p;
        end
        chk("t3_total_pulses", acc_p, 3);

        // Enabling with the pin already high produces no edge.
        en = 0; edge_sel = 2'b01; pre = 0; ev_in = 1;
        repeat (20) step();
        en = 1;
        run_rec(10, p, e, f);
        chk("t4_en_pulses", p, 0);
        chk("t4_en_lvl", ev_level, 1);
        ev_in = 0; repeat (5) step();
        ev_in = 1; run_rec(5, p, e, f);
        chk("t4_next_pulse", p, 1);

        // Lowering pre below the current count terminates on the next edge.
        pre = 5;
        en = 0; step(); en = 1;
        ev_in = 0; repeat (4) step();
        acc_p = 0;
        for (int i = 1; i <= 4; i++) begin
            ev_in = 1; run_rec(3, p, e, f); acc_p += p;
            ev_in = 0; run_rec(3, p, e, f); acc_p += p;
        end
        chk("t5_pre5_pulses", acc_p, 0);
        pre = 1;
        for (int i = 5; i <= 8; i++) begin
            ev_in = 1; run_rec(3, p, e, f);
            ev_in = 0; run_rec(3, p2, e2, f2);
            chk("t5_pulse", p + p2, (i == 5 || i == 7) ? 1 : 0);
        end

        // Reset mid-filter and mid-prescale discards partial counts.
        flt_len = 3; edge_sel = 2'b11; pre = 3;
        en = 0; step(); en = 1;
        ev_in = 1; run_rec(8, p, e, f);
        chk("t6_pre_edge", e, 1);
        ev_in = 0;
        repeat (4) step();
        async_reset_check("t6_rst");
        for (int i = 1; i <= 4; i++) begin
            ev_in = ~ev_in;
            run_rec(6, p, e, f);
            chk("t6_edge", e, 1);
            chk("t6_pulse", p, (i == 4) ? 1 : 0);
        end

        // Randomized configuration and pin activity against the model.
        hold = 0;
        for (int blk = 0; blk < 60; blk++) begin
            en = 0;
            pol = 1'($urandom);
            step();
            flt_len  = FW'($urandom_range(0, 4));
            pre      = PW'($urandom_range(0, 4));
            edge_sel = 2'($urandom);
            en = ($urandom_range(0, 5) != 0);
            for (int k = 0; k < 50; k++) begin
                if (hold == 0) begin
                    ev_in = 1'($urandom);
                    hold = $urandom_range(1, 8);
                end
                hold--;
                step();
                if ($urandom_range(0, 300) == 0) async_reset_check("rnd_rst");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ef_tcc32_evt_cond.md
# ef_tcc32_evt_cond

External-event input conditioner that sits directly upstream of the EF_TCC32 timer/counter/capture core's `ext_clk` input. It synchronises an asynchronous pin and rejects glitches with a programmable digital filter. It then selects the active edge(s) and optionally prescales them. The core receives a clean, single-cycle event strobe usable both for external-clock counting and for capture. All configuration inputs come from the TCC32 register file.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth; legal range 2–4.
- `FLT_W`, default 4: width of the filter length field and filter counter.
- `PRE_W`, default 8: width of the prescaler field and prescaler counter.

Ports:
- `clk`  in  1  sole clock, rising-edge.
- `rst_n`  in  1  reset, **asynchronous, active-low**.
- `en`  in  1  conditioner enable.
- `ev_in`  in  1  raw asynchronous external pin.
- `pol`  in  1  1 = invert `ev_in` before filtering.
- `flt_len`  in  FLT_W  required consecutive mismatch cycles minus 1; 0 = one-cycle filter.
- `edge_sel`  in  2  edge select: 00 none, 01 rising, 10 falling, 11 both.
- `pre`  in  PRE_W  emit one `ev_pulse` per `pre`+1 qualified edges.
- `ev_level`  out  1  filtered, polarity-corrected level.
- `ev_edge`  out  1  one-cycle strobe per qualified edge, before prescaling (for capture).
- `ev_pulse`  out  1  one-cycle strobe after prescaling (drives TCC32 `ext_clk` path).

## Operation
- Input stage: `x = ev_in ^ pol`, passed through a `SYNC_STAGES`-flop synchroniser; its output is `s`.
- Filter: a counter `fcnt` (FLT_W) and register `ev_level`.
  - If `s == ev_level`, `fcnt` is cleared to 0.
  - If `s != ev_level` and `fcnt >= flt_len`, `ev_level` is set to `s` and `fcnt` is cleared; this is a level change.
  - Otherwise `fcnt` increments.
  - A pulse must therefore be stable for `flt_len`+1 cycles at `s` to pass.
- Edge qualify: a level change with a new value of 1 is rising; a new value of 0 is falling. The change is qualified when `edge_sel` enables that direction.
- Prescaler: a counter `pcnt` (PRE_W).
  - On a qualified edge with `pcnt >= pre`: `pcnt` goes to 0 and `ev_pulse` is asserted.
  - On a qualified edge otherwise: `pcnt` increments.
- `en = 0`:
  - `ev_level` tracks `s` every cycle and `fcnt` is held at 0.
  - `pcnt` is held at 0.
  - `ev_edge` and `ev_pulse` stay 0.
  - Consequence: enabling never produces a spurious edge from a pre-existing pin level.
- Config changes take effect on the next cycle. The `>=` compares guarantee termination when `flt_len` or `pre` is lowered below the current count.
- `pol` toggled while `en = 1` is treated as a real input transition and is filtered like one. Firmware must change `pol` only with `en = 0`.

## Timing
- Reset: synchroniser flops, `fcnt`, `pcnt`, `ev_level`, `ev_edge` and `ev_pulse` are all 0, and reset takes effect immediately. Reset asserted mid-filter or mid-prescale discards all partial counts.
- Latency: `ev_in` is sampled at edge 1. `ev_level`, `ev_edge` and `ev_pulse` update at edge `SYNC_STAGES + flt_len + 1`. With defaults and `flt_len = 0`, that is edge 3.
- `ev_edge` and `ev_pulse` are registered, exactly one cycle wide, and never asserted on consecutive cycles when `flt_len >= 1`.
- Edge to `ev_edge` to `ev_pulse` is zero extra cycles; both derive from the same level-change condition.
- Maximum qualified-edge rate is one edge per `flt_len`+1 cycles. The bench's ext_clk, with a half-period of 8.65 clk, passes cleanly at `flt_len <= 7`.

## Structure
- Shared package `ef_tcc32_pkg` holds the `edge_sel` encodings `EDGE_NONE`, `EDGE_RISE`, `EDGE_FALL` and `EDGE_BOTH`. It also holds the default widths, which the TCC32 register file reuses for its fields.
- One sub-module, `ef_sync`: a parameterised N-stage synchroniser with async active-low reset and reset value 0. The filter, edge and prescale logic stay in the top module.

## Test plan
- Defaults, `en = 1`, `pol = 0`, `flt_len = 0`, `edge_sel = 01`, `pre = 0`; drive `ev_in` 0 to 1 held 10 cycles → `ev_level` rises and a single `ev_pulse` and `ev_edge` fire at edge 3; the falling edge produces no pulse.
- `flt_len = 3`: 3-cycle glitch on `ev_in` → no change to `ev_level` and no pulse; then a 4-cycle high pulse → exactly one `ev_pulse`, at edge 2+3+1 = 6.
- `edge_sel = 11`, `pre = 2`, square wave of 9 edges → 9 `ev_edge` strobes and 3 `ev_pulse` strobes (on edges 3, 6 and 9).
- `ev_in` held high with `en = 0` for 20 cycles, then `en = 1` with `edge_sel = 01` → no pulse, `ev_level = 1`. Next low-to-high transition → one pulse.
- `pre = 5`, after 4 edges write `pre = 1` → the next qualified edge emits `ev_pulse` and `pcnt` returns to 0; subsequent pulses occur every 2 edges.
- Assert `rst_n` low mid-filter, with `fcnt = 2` and `pcnt = 1` → all outputs 0 asynchronously; after release, counting restarts from 0 with no stray pulse.
